// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads a time-multiplexed, active-low 7-segment display bus.
// Each digit-select/segment pattern must stay stable for STABLE_CYC+1 samples
// before it is captured. The pattern is then converted back to a BCD digit, or
// flagged as blank or invalid, and stored against the position that was selected.
// Optional feature: define SEG_SCAN_DP_EN to add the decimal-point input
// (dp_in, active-low) and the captured decimal-point output (dp_out).
module seg_scan_decoder #(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4,
    parameter int IW         = $clog2(NDIG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NDIG-1:0]     an_in,
    input  logic [6:0]          seg_in,
`ifdef SEG_SCAN_DP_EN
    input  logic                dp_in,
    output logic [NDIG-1:0]     dp_out,
`endif
    output logic [4*NDIG-1:0]   digits_out,
    output logic [NDIG-1:0]     blank_out,
    output logic [NDIG-1:0]     err_out,
    output logic [IW-1:0]       cur_idx,
    output logic                cap_pulse,
    output logic                frame_valid,
    output logic                sel_err
);

    localparam int CW = $clog2(STABLE_CYC + 1);
`ifdef SEG_SCAN_DP_EN
    localparam int SW = NDIG + 8;
`else
    localparam int SW = NDIG + 7;
`endif

    // Live bus snapshot and the copy taken on the previous edge.
    logic [SW-1:0]   samp_live;
    logic [SW-1:0]   s_q;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            sel_valid;
    logic [IW-1:0]   sel_pos;
    logic            same;
    logic            capture;

    logic [3:0]      dec_digit;
    logic            dec_blank;
    logic            dec_err;

    logic [NDIG-1:0] seen_q;
    logic [NDIG-1:0] seen_set;
    logic            frame_done;

    logic [IW-1:0]   cur_idx_q;
    logic            cap_pulse_q;
    logic            frame_valid_q;
    logic            sel_err_q, sel_err_d;

    logic [3:0]      digit_q [NDIG];
    logic            blank_q [NDIG];
    logic            err_q   [NDIG];

`ifdef SEG_SCAN_DP_EN
    logic            dp_q    [NDIG];
    assign samp_live = {dp_in, an_in, seg_in};
`else
    assign samp_live = {an_in, seg_in};
`endif

    assign same = (samp_live == s_q);

    // Select decode: a valid select has exactly one bit set; also report its index.
    always_comb begin
        int hits;
        hits    = 0;
        sel_pos = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (an_in[i]) begin
                hits    = hits + 1;
                sel_pos = IW'(i);
            end
        end
        sel_valid = (hits == 1);
    end

    // Stability counter and input sample register (cnt encodes IDLE/COUNT/HELD).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            s_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            s_q   <= samp_live;
        end
    end

    // Next count: restart on change or bad select, advance while stable, saturate at HELD.
    always_comb begin
        cnt_d = cnt_q;
        if (!sel_valid || !same) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STABLE_CYC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Capture fires on the single step from STABLE_CYC-1 into HELD.
    always_comb begin
        capture = sel_valid && same && (cnt_q == CW'(STABLE_CYC - 1));
    end

    // Segment pattern to BCD; unknown patterns and blank both store 4'hF.
    always_comb begin
        dec_digit = 4'hF;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_in)
            7'b0000001: dec_digit = 4'd0;
            7'b1001111: dec_digit = 4'd1;
            7'b0010010: dec_digit = 4'd2;
            7'b0000110: dec_digit = 4'd3;
            7'b1001100: dec_digit = 4'd4;
            7'b0100100: dec_digit = 4'd5;
            7'b0100000: dec_digit = 4'd6;
            7'b0001111: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0000100: dec_digit = 4'd9;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    // Frame tracking: a valid select is already the one-hot bit of the position.
    assign seen_set   = seen_q | an_in;
    assign frame_done = capture && (seen_set == {NDIG{1'b1}});

    // A bad select always wins over the frame-completion clear.
    always_comb begin
        sel_err_d = sel_err_q;
        if (!sel_valid) begin
            sel_err_d = 1'b1;
        end else if (frame_done) begin
            sel_err_d = 1'b0;
        end
    end

    // Capture bookkeeping: strobes, last index, seen mask and sticky select error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_idx_q     <= '0;
            cap_pulse_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            seen_q        <= '0;
            sel_err_q     <= 1'b0;
        end else begin
            cap_pulse_q   <= capture;
            frame_valid_q <= frame_done;
            sel_err_q     <= sel_err_d;
            if (capture) begin
                cur_idx_q <= sel_pos;
                seen_q    <= frame_done ? '0 : seen_set;
            end
        end
    end

    // Per-position result storage, written only when that position is captured.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_pos
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    digit_q[gi] <= 4'h0;
                    blank_q[gi] <= 1'b1;
                    err_q[gi]   <= 1'b0;
                end else if (capture && (sel_pos == IW'(gi))) begin
                    digit_q[gi] <= dec_digit;
                    blank_q[gi] <= dec_blank;
                    err_q[gi]   <= dec_err;
                end
            end

            assign digits_out[4*gi +: 4] = digit_q[gi];
            assign blank_out[gi]         = blank_q[gi];
            assign err_out[gi]           = err_q[gi];

`ifdef SEG_SCAN_DP_EN
            // Decimal point is active-low on the bus, stored active-high.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dp_q[gi] <= 1'b0;
                end else if (capture && (sel_pos == IW'(gi))) begin
                    dp_q[gi] <= ~dp_in;
                end
            end

            assign dp_out[gi] = dp_q[gi];
`endif
        end
    endgenerate

    assign cur_idx     = cur_idx_q;
    assign cap_pulse   = cap_pulse_q;
    assign frame_valid = frame_valid_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: directed scenarios plus random scanning,
// checked by a scoreboard fed from a pattern-run reference model.
module tb_seg_scan_decoder;

    localparam int NDIG = 8;
    localparam int S    = 4;
    localparam int IW   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NDIG-1:0]   an_in = '0;
    logic [6:0]        seg_in = 7'h7F;
    logic [4*NDIG-1:0] digits_out;
    logic [NDIG-1:0]   blank_out;
    logic [NDIG-1:0]   err_out;
    logic [IW-1:0]     cur_idx;
    logic              cap_pulse;
    logic              frame_valid;
    logic              sel_err;
`ifdef SEG_SCAN_DP_EN
    logic              dp_in = 1'b1;
    logic [NDIG-1:0]   dp_out;
`endif

    seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .an_in       (an_in),
        .seg_in      (seg_in),
`ifdef SEG_SCAN_DP_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .cur_idx     (cur_idx),
        .cap_pulse   (cap_pulse),
        .frame_valid (frame_valid),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    // Active-low segment codes for digits 0..9.
    logic [6:0] tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    typedef struct {
        logic [IW-1:0]     idx;
        logic [4*NDIG-1:0] dig;
        logic [NDIG-1:0]   blank;
        logic [NDIG-1:0]   err;
        logic              fv;
        logic              se;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cap_cnt = 0;
    int fv_cnt = 0;

    // Reference model state: a pattern is captured when it has been seen on
    // exactly S+1 consecutive edges with a one-hot select.
    logic [NDIG+6:0] m_prev;
    int              m_run;
    logic [3:0]      m_dig [NDIG];
    logic [NDIG-1:0] m_blank, m_err, m_seen;
    logic            m_sel_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_run = 0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = 4'h0;
        m_blank = '1;
        m_err = '0;
        m_seen = '0;
        m_sel_err = 1'b0;
        q.delete();
    endtask

    // Model: evaluated on every active edge from the inputs presented to it.
    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            logic [NDIG+6:0] x;
            logic            valid;
            int              p;
            exp_t            e;
            x = {an_in, seg_in};
            valid = ($countones(an_in) == 1);
            if (x == m_prev) m_run++; else m_run = 1;
            m_prev = x;
            if (!valid) m_sel_err = 1'b1;
            if (valid && m_run == S + 1) begin
                p = 0;
                for (int i = 0; i < NDIG; i++) if (an_in[i]) p = i;
                m_dig[p] = 4'hF;
                m_blank[p] = (seg_in == 7'h7F);
                m_err[p] = (seg_in != 7'h7F);
                for (int d = 0; d < 10; d++) begin
                    if (seg_in == tbl[d]) begin
                        m_dig[p] = 4'(d);
                        m_err[p] = 1'b0;
                    end
                end
                m_seen[p] = 1'b1;
                e.fv = (m_seen == '1);
                if (e.fv) begin
                    m_seen = '0;
                    m_sel_err = 1'b0;
                end
                e.idx = IW'(p);
                for (int i = 0; i < NDIG; i++) e.dig[4*i +: 4] = m_dig[i];
                e.blank = m_blank;
                e.err = m_err;
                e.se = m_sel_err;
                q.push_back(e);
            end
        end
    end

    // Monitor: checks outputs on the falling edge, popping on every capture strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (cap_pulse) begin
                exp_t e;
                cap_cnt++;
                if (frame_valid) fv_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cap: got cap_pulse=1 expected 0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("cur_idx", 32'(cur_idx), 32'(e.idx));
                    chk("digits_out", digits_out, e.dig);
                    chk("blank_out", 32'(blank_out), 32'(e.blank));
                    chk("err_out", 32'(err_out), 32'(e.err));
                    chk("frame_valid", 32'(frame_valid), 32'(e.fv));
                    $display("cap idx=%0d digits=%08h blank=%02h err=%02h fv=%0b", cur_idx, digits_out,
                             blank_out, err_out, frame_valid);
                end
            end else begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_cap: got cap_pulse=0 expected 1 at %0t", $time);
                    void'(q.pop_front());
                end
                chk("frame_valid_idle", 32'(frame_valid), 32'd0);
            end
            chk("sel_err", 32'(sel_err), 32'(m_sel_err));
        end
    end

    // Present a pattern from the current falling edge for n active edges.
    task automatic hold(input logic [NDIG-1:0] a, input logic [6:0] s, input int n);
        an_in = a;
        seg_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_digits", digits_out, 32'd0);
        chk("rst_blank", 32'(blank_out), 32'hFF);
        chk("rst_err", 32'(err_out), 32'd0);
        chk("rst_idx", 32'(cur_idx), 32'd0);
        chk("rst_strobes", {30'd0, cap_pulse, frame_valid}, 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
    endtask

    // Assert reset mid-cycle, check the asynchronous values, release on a falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_reset_values();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, f0;
        repeat (3) @(negedge clk);

        // Capture lands exactly on the fifth edge after the pattern appears.
        do_reset();
        c0 = cap_cnt;
        hold(8'h04, 7'b0010010, 4);
        #1 chk("t1_no_cap_edge4", 32'(cap_cnt - c0), 32'd0);
        hold(8'h04, 7'b0010010, 1);
        #1 chk("t1_cap_edge5", 32'(cap_cnt - c0), 32'd1);
        chk("t1_digit2", 32'(digits_out[11:8]), 32'd2);
        chk("t1_cur_idx", 32'(cur_idx), 32'd2);
        chk("t1_err", 32'(err_out), 32'd0);
        chk("t1_blank2", 32'(blank_out[2]), 32'd0);

        // An early change restarts the count; a held pattern captures only once.
        do_reset();
        c0 = cap_cnt;
        hold(8'h01, 7'b0000110, 3);
        hold(8'h01, 7'b1001100, 5);
        hold(8'h01, 7'b1001100, 20);
        #1 chk("t2_single_cap", 32'(cap_cnt - c0), 32'd1);
        chk("t2_digit0", 32'(digits_out[3:0]), 32'd4);

        // Full scan completes a frame on the eighth capture.
        do_reset();
        c0 = cap_cnt;
        f0 = fv_cnt;
        for (int i = 0; i < NDIG; i++) hold(8'(1 << i), tbl[i], 6);
        #1 chk("t3_caps", 32'(cap_cnt - c0), 32'd8);
        chk("t3_frames", 32'(fv_cnt - f0), 32'd1);
        chk("t3_digits", digits_out, 32'h76543210);

        // Bad selects set the sticky error; the next full frame clears it.
        c0 = cap_cnt;
        f0 = fv_cnt;
        hold(8'h00, 7'b0000001, 6);
        hold(8'h03, 7'b0000001, 6);
        #1 chk("t4_no_cap", 32'(cap_cnt - c0), 32'd0);
        chk("t4_sel_err_set", 32'(sel_err), 32'd1);
        for (int i = 0; i < NDIG; i++) hold(8'(1 << i), tbl[9 - i], 6);
        #1 chk("t4_frame", 32'(fv_cnt - f0), 32'd1);
        chk("t4_sel_err_clr", 32'(sel_err), 32'd0);

        // Blank and undecodable patterns.
        hold(8'h20, 7'b1111111, 6);
        hold(8'h40, 7'b1010101, 6);
        #1 chk("t5_blank5", 32'(blank_out[5]), 32'd1);
        chk("t5_digit5", 32'(digits_out[23:20]), 32'hF);
        chk("t5_err6", 32'(err_out[6]), 32'd1);
        chk("t5_digit6", 32'(digits_out[27:24]), 32'hF);

        // Reset during counting discards the partial history.
        c0 = cap_cnt;
        hold(8'h10, 7'b0100100, 2);
        do_reset();
        #1 chk("t6_no_cap_before", 32'(cap_cnt - c0), 32'd0);
        hold(8'h10, 7'b0100100, 4);
        #1 chk("t6_no_cap_edge4", 32'(cap_cnt - c0), 32'd0);
        hold(8'h10, 7'b0100100, 1);
        #1 chk("t6_cap_edge5", 32'(cap_cnt - c0), 32'd1);

        // Random scanning with mixed hold lengths, patterns and occasional bad selects.
        for (int n = 0; n < 300; n++) begin
            logic [NDIG-1:0] a;
            logic [6:0]      s;
            int              r;
            if ($urandom_range(0, 9) == 0) a = NDIG'($urandom);
            else a = NDIG'(1 << $urandom_range(0, NDIG - 1));
            r = $urandom_range(0, 9);
            if (r < 6) s = tbl[$urandom_range(0, 9)];
            else if (r < 8) s = 7'h7F;
            else s = 7'($urandom);
            hold(a, s, $urandom_range(1, 8));
        end

        hold(8'h00, 7'h7F, 3);
        #1 chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
